sd_img_server: RTL

SD_IMG_SERVER -- requirements
Module: sd_img_server

---
 rtl/sd_img_server_pkg.sv | 27 ++
 rtl/sd_img_arb.sv | 35 +++
 rtl/sd_img_server.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sd_img_server_pkg.sv
// Shared types and constants for the SD image server and its drive arbiter.
package sd_img_server_pkg;

    localparam int BLK_BYTES          = 256;
    localparam int DRIVE_STRIDE_SHIFT = 24;

    typedef enum logic [2:0] {
        IDLE,
        RD_MEM,
        RD_PUT,
        WR_ADDR,
        WR_LAT,
        WR_MEM,
        DONE
    } srv_state_t;

    function automatic int ndr_clamp(input int drives);
        if (drives < 1) return 1;
        if (drives > 4) return 4;
        return drives;
    endfunction

    function automatic int idx_width(input int ndr);
        return (ndr > 1) ? $clog2(ndr) : 1;
    endfunction

endpackage

// File: rtl/sd_img_arb.sv
// Round-robin drive arbiter: the first requester after the last-served drive wins.
module sd_img_arb
    import sd_img_server_pkg::*;
#(
    parameter int  NDR = 2,
    localparam int IW  = idx_width(NDR)
) (
    input  logic [NDR-1:0] req,
    input  logic [IW-1:0]  last_idx,
    output logic [NDR-1:0] grant,
    output logic [IW-1:0]  grant_idx,
    output logic           grant_any
);

    int best;

    // Distance from last-served drive decides priority; smallest distance wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        best      = NDR;
        for (int j = 0; j < NDR; j++) begin
            if (req[j] && ((j - int'(last_idx) - 1 + 2 * NDR) % NDR) < best) begin
                best      = (j - int'(last_idx) - 1 + 2 * NDR) % NDR;
                grant_idx = IW'(j);
                grant_any = 1'b1;
            end
        end
        for (int j = 0; j < NDR; j++) begin
            grant[j] = grant_any && (int'(grant_idx) == j);
        end
    end

endmodule

// File: rtl/sd_img_server.sv
// Serves per-drive SD block requests from a byte-wide image store, one drive at a time.
module sd_img_server
    import sd_img_server_pkg::*;
#(
    parameter int  DRIVES = 2,
    localparam int NDR    = ndr_clamp(DRIVES),
    localparam int IW     = idx_width(NDR)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [NDR-1:0]    img_mounted,
    input  logic [31:0]       img_size,
    input  logic [31:0]       sd_lba [NDR],
    input  logic [5:0]        sd_blk_cnt [NDR],
    input  logic [NDR-1:0]    sd_rd,
    input  logic [NDR-1:0]    sd_wr,
    output logic [NDR-1:0]    sd_ack,
    output logic [13:0]       sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    input  logic [7:0]        sd_buff_din [NDR],
    output logic              sd_buff_wr,
    output logic [31:0]       mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready
);

    srv_state_t     state, state_next;
    logic [IW-1:0]  drv, rr_last;
    logic [15:0]    lba;
    logic [13:0]    offset, last_off;
    logic [31:0]    size_lat;
    logic [31:0]    sizes [NDR];
    logic [NDR-1:0] armed;
    logic [31:0]    rel_addr;
    logic           beyond, is_last;
    logic [NDR-1:0] grant;
    logic [IW-1:0]  grant_idx;
    logic           grant_any;
    logic           do_grant, issue_rd, issue_wr, put_mem, put_zero, advance;
    logic           unused_lba_hi;

    always_comb begin
        unused_lba_hi = 1'b0;
        for (int i = 0; i < NDR; i++) unused_lba_hi = unused_lba_hi ^ (^sd_lba[i][31:16]);
    end

    assign rel_addr     = {8'd0, lba, 8'd0} + {18'd0, offset};
    assign mem_addr     = (32'(drv) << DRIVE_STRIDE_SHIFT) + rel_addr;
    assign beyond       = rel_addr >= size_lat;
    assign is_last      = offset == last_off;
    assign sd_buff_addr = offset;

    sd_img_arb #(.NDR(NDR)) u_arb (
        .req       ((sd_rd | sd_wr) & armed),
        .last_idx  (rr_last),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Each byte costs one idle cycle in RD_MEM before the request, so reads run at 3 cycles/byte.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
        put_mem    = 1'b0;
        put_zero   = 1'b0;
        advance    = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    do_grant   = 1'b1;
                    state_next = sd_rd[grant_idx] ? RD_MEM : WR_ADDR;
                end
            end
            RD_MEM: begin
                if (!mem_rd) begin
                    if (beyond) begin
                        put_zero   = 1'b1;
                        state_next = RD_PUT;
                    end else begin
                        issue_rd = 1'b1;
                    end
                end else if (mem_ready) begin
                    put_mem    = 1'b1;
                    state_next = RD_PUT;
                end
            end
            RD_PUT: begin
                advance    = 1'b1;
                state_next = is_last ? DONE : RD_MEM;
            end
            WR_ADDR: state_next = WR_LAT;
            WR_LAT:  state_next = WR_MEM;
            WR_MEM: begin
                if (!mem_wr) begin
                    if (beyond) begin
                        advance    = 1'b1;
                        state_next = is_last ? DONE : WR_ADDR;
                    end else begin
                        issue_wr = 1'b1;
                    end
                end else if (mem_ready) begin
                    advance    = 1'b1;
                    state_next = is_last ? DONE : WR_ADDR;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A drive re-arms only once it has dropped both request lines while not being served.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            drv          <= '0;
            rr_last      <= '0;
            lba          <= '0;
            offset       <= '0;
            last_off     <= '0;
            size_lat     <= '0;
            armed        <= '1;
            sd_ack       <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wdata    <= '0;
            for (int i = 0; i < NDR; i++) sizes[i] <= '0;
        end else begin
            for (int i = 0; i < NDR; i++) begin
                if (img_mounted[i]) sizes[i] <= img_size;
                if (!sd_ack[i] && !sd_rd[i] && !sd_wr[i]) armed[i] <= 1'b1;
            end
            if (do_grant) begin
                drv              <= grant_idx;
                rr_last          <= grant_idx;
                lba              <= sd_lba[grant_idx][15:0];
                last_off         <= {sd_blk_cnt[grant_idx], 8'(BLK_BYTES - 1)};
                size_lat         <= sizes[grant_idx];
                offset           <= '0;
                armed[grant_idx] <= 1'b0;
                sd_ack           <= grant;
            end
            mem_rd     <= issue_rd | (mem_rd & ~mem_ready);
            mem_wr     <= issue_wr | (mem_wr & ~mem_ready);
            sd_buff_wr <= put_mem | put_zero;
            if (put_mem)  sd_buff_dout <= mem_rdata;
            if (put_zero) sd_buff_dout <= 8'h00;
            if (issue_wr) mem_wdata    <= sd_buff_din[drv];
            if (advance) begin
                if (is_last) sd_ack <= '0;
                else         offset <= offset + 14'd1;
            end
        end
    end

endmodule
